// File: rtl/fme_pipe_pkg.sv
// fme_pipe_pkg
// Shared constants for the pipe_barrier family: default geometry of the
// barrier (channel width, channel count, stage count) and the width of the
// optional output-transfer counter.
package fme_pipe_pkg;

    localparam int DEFAULT_DATAWIDTH = 8;
    localparam int DEFAULT_NUM_CH    = 8;
    localparam int DEFAULT_DEPTH     = 2;
    localparam int BEAT_COUNT_W      = 32;

    typedef logic [BEAT_COUNT_W-1:0] beat_count_t;

endpackage

// File: rtl/pipe_barrier_stage.sv
// pipe_stage
// One register stage of the barrier: a valid bit plus a data word.
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous active-low reset; clears valid and data
//   advance     stage may take a new occupant this cycle
//   flush       synchronous clear of the valid bit (data is kept)
//   load_valid  valid bit offered by the upstream side
//   load_data   data word offered by the upstream side
//   valid       stage holds a beat
//   data        held data word
module pipe_stage
    import fme_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATAWIDTH * DEFAULT_NUM_CH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             advance,
    input  logic             flush,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Flush wins over advance and leaves the data word untouched. The data
    // word is only rewritten when a real beat arrives, so an emptied stage
    // keeps showing its last contents.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (advance) begin
            valid <= load_valid;
            if (load_valid) begin
                data <= load_data;
            end
        end
    end

endmodule

// File: rtl/pipe_barrier.sv
// pipe_barrier
// Multi-channel valid/ready register pipeline of DEPTH stages with bubble
// collapse. All NUM_CH channels travel together as one word.
//
// Configuration macro: PIPE_BARRIER_STATS_EN
//   defined   -> beat_count counts output transfers (wraps, ignores flush)
//   undefined -> beat_count is tied to zero, no counter is built
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   flush       synchronous clear of all stages, active-high
//   in_valid    upstream beat present
//   in_ready    barrier accepts a beat this cycle
//   in_data     NUM_CH*DATAWIDTH, channel k at [k*DATAWIDTH +: DATAWIDTH]
//   out_valid   last stage holds a beat
//   out_ready   downstream accepts a beat
//   out_data    last-stage word, same packing as in_data
//   occupancy   number of valid stages
//   beat_count  output transfer count (see macro above)
module pipe_barrier
    import fme_pipe_pkg::*;
#(
    parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
    parameter int NUM_CH    = DEFAULT_NUM_CH,
    parameter int DEPTH     = DEFAULT_DEPTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_CH*DATAWIDTH-1:0]   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_CH*DATAWIDTH-1:0]   out_data,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy,
    output logic [BEAT_COUNT_W-1:0]       beat_count
);

    localparam int WORD_W = NUM_CH * DATAWIDTH;
    localparam int OCC_W  = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  stage_valid;
    logic [WORD_W-1:0] stage_data [DEPTH];
    logic [DEPTH:0]    advance;
    logic              accept;

    // A stage may take a new occupant when it is empty or when its own
    // occupant is leaving downstream. Evaluated from the output side back
    // so an empty stage anywhere lets everything behind it close the gap.
    always_comb begin
        advance        = '0;
        advance[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            advance[i] = ~stage_valid[i] | advance[i+1];
        end
    end

    // Gating with reset keeps in_ready low while the pipe is held in reset,
    // even though every stage then looks empty.
    assign in_ready  = advance[0] & ~flush & reset;
    assign accept    = in_valid & in_ready;
    assign out_valid = stage_valid[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic              load_valid_i;
        logic [WORD_W-1:0] load_data_i;

        if (i == 0) begin : g_head
            assign load_valid_i = accept;
            assign load_data_i  = in_data;
        end else begin : g_body
            assign load_valid_i = stage_valid[i-1];
            assign load_data_i  = stage_data[i-1];
        end

        pipe_stage #(
            .WIDTH (WORD_W)
        ) u_stage (
            .clock      (clock),
            .reset      (reset),
            .advance    (advance[i]),
            .flush      (flush),
            .load_valid (load_valid_i),
            .load_data  (load_data_i),
            .valid      (stage_valid[i]),
            .data       (stage_data[i])
        );
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(stage_valid[i]);
        end
    end

`ifdef PIPE_BARRIER_STATS_EN
    beat_count_t beat_count_q;

    // Counts every output transfer, including one that coincides with a
    // flush; wraps naturally at the counter width.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            beat_count_q <= '0;
        end else if (out_valid & out_ready) begin
            beat_count_q <= beat_count_q + BEAT_COUNT_W'(1);
        end
    end

    assign beat_count = beat_count_q;
`else
    assign beat_count = '0;
`endif

endmodule

// File: tb/tb_pipe_barrier.sv
// tb_pipe_barrier
// Self-checking bench for pipe_barrier. Main instance uses the defaults
// (8-bit channels, 8 channels, 2 stages); a second instance uses one 8-bit
// channel and a single stage. Expected behaviour comes from directed
// constants and from a queue-of-beats reference model.
module tb_pipe_barrier;

    localparam int DW  = 8;
    localparam int NCH = 8;
    localparam int DEP = 2;
    localparam int W   = DW * NCH;

`ifdef PIPE_BARRIER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;
    logic [31:0]   beat_count;

    logic          flush1;
    logic          in_valid1;
    logic          in_ready1;
    logic [7:0]    in_data1;
    logic          out_valid1;
    logic          out_ready1;
    logic [7:0]    out_data1;
    logic [0:0]    occupancy1;
    logic [31:0]   beat_count1;

    int vectors;
    int miscompares;

    always #5 clock = ~clock;

    pipe_barrier #(
        .DATAWIDTH (DW),
        .NUM_CH    (NCH),
        .DEPTH     (DEP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy),
        .beat_count (beat_count)
    );

    pipe_barrier #(
        .DATAWIDTH (8),
        .NUM_CH    (1),
        .DEPTH     (1)
    ) dut1 (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush1),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
        .in_data    (in_data1),
        .out_valid  (out_valid1),
        .out_ready  (out_ready1),
        .out_data   (out_data1),
        .occupancy  (occupancy1),
        .beat_count (beat_count1)
    );

    // Reference model: beats in flight, oldest first, each tagged with the
    // stage it sits in. The virtual slot "mdepth" is the downstream sink.
    typedef struct {
        logic [63:0] data;
        int          pos;
    } beat_t;

    beat_t mq[$];
    int    mdepth;
    int    m_out_count;

    function automatic void model_reset();
        mq.delete();
        m_out_count = 0;
    endfunction

    // A beat moves when the slot ahead of it is free or is being vacated.
    function automatic bit model_in_ready(input logic ordy, input logic fl);
        int prev_pos;
        bit prev_moved;
        if (fl) return 1'b0;
        prev_pos   = mdepth;
        prev_moved = ordy;
        foreach (mq[k]) begin
            prev_moved = (prev_pos != mq[k].pos + 1) || prev_moved;
            prev_pos   = mq[k].pos;
        end
        return (prev_pos != 0) || prev_moved;
    endfunction

    function automatic void model_step(input logic iv, input logic [63:0] id,
                                       input logic ordy, input logic fl);
        bit    acc;
        int    prev_pos;
        bit    prev_moved;
        bit    mv;
        beat_t b;
        beat_t nq[$];
        acc        = iv && model_in_ready(ordy, fl);
        prev_pos   = mdepth;
        prev_moved = ordy;
        foreach (mq[k]) begin
            mv         = (prev_pos != mq[k].pos + 1) || prev_moved;
            prev_pos   = mq[k].pos;
            prev_moved = mv;
            b          = mq[k];
            if (mv && b.pos == mdepth - 1) begin
                m_out_count++;
            end else begin
                if (mv) b.pos++;
                nq.push_back(b);
            end
        end
        if (fl) nq.delete();
        if (acc) begin
            b.data = id;
            b.pos  = 0;
            nq.push_back(b);
        end
        mq = nq;
    endfunction

    function automatic bit model_out_valid();
        if (mq.size() == 0) return 1'b0;
        return mq[0].pos == mdepth - 1;
    endfunction

    task automatic drive(input logic iv, input logic [W-1:0] id,
                         input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, 1'b0);
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        in_data1   = '0;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        tick();
    endtask

    localparam logic [63:0] WA = 64'h0706050403020100;
    localparam logic [63:0] WB = 64'h0F0E0D0C0B0A0908;
    localparam logic [63:0] WC = 64'h1716151413121110;
    localparam logic [63:0] WD = 64'hA5A4A3A2A1A0AFAE;

    task automatic test_reset();
        drive(1'b1, WA, 1'b1, 1'b0);
        #3;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
        vectors++;
        if (out_data !== '0) begin miscompares++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
        vectors++;
        if (occupancy !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_occupancy: got %0d expected 0", occupancy); end
        vectors++;
        if (beat_count !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_beat_count: got %0d expected 0", beat_count); end
        do_reset();
    endtask

    task automatic test_streaming();
        do_reset();
        drive(1'b1, WA, 1'b1, 1'b0);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL stream_ready_a: got %b expected 1", in_ready); end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || occupancy !== 2'd1) begin miscompares++; $display("[TB] FAIL stream_first_edge: got valid %b occ %0d expected valid 0 occ 1", out_valid, occupancy); end
        drive(1'b1, WB, 1'b1, 1'b0);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL stream_ready_b: got %b expected 1", in_ready); end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== WA) begin miscompares++; $display("[TB] FAIL stream_out_a: got valid %b data %h expected 1 %h", out_valid, out_data, WA); end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== WB) begin miscompares++; $display("[TB] FAIL stream_out_b: got valid %b data %h expected 1 %h", out_valid, out_data, WB); end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin miscompares++; $display("[TB] FAIL stream_drained: got valid %b occ %0d expected 0 0", out_valid, occupancy); end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b1, WA, 1'b0, 1'b0);
        tick();
        drive(1'b1, WB, 1'b0, 1'b0);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_ready_b: got %b expected 1", in_ready); end
        tick();
        vectors++;
        if (occupancy !== 2'd2 || out_data !== WA) begin miscompares++; $display("[TB] FAIL bp_full: got occ %0d data %h expected 2 %h", occupancy, out_data, WA); end
        drive(1'b1, WC, 1'b0, 1'b0);
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_ready_c: got %b expected 0", in_ready); end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== WA || occupancy !== 2'd2) begin miscompares++; $display("[TB] FAIL bp_hold: got valid %b data %h occ %0d expected 1 %h 2", out_valid, out_data, occupancy, WA); end
        drive(1'b1, WC, 1'b1, 1'b0);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_full_passthru: got %b expected 1", in_ready); end
        tick();
        vectors++;
        if (out_data !== WB || occupancy !== 2'd2) begin miscompares++; $display("[TB] FAIL bp_out_b: got data %h occ %0d expected %h 2", out_data, occupancy, WB); end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== WC) begin miscompares++; $display("[TB] FAIL bp_out_c: got valid %b data %h expected 1 %h", out_valid, out_data, WC); end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, WA, 1'b0, 1'b0);
        tick();
        drive(1'b1, WB, 1'b0, 1'b0);
        tick();
        drive(1'b1, WC, 1'b0, 1'b1);
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_in_ready: got %b expected 0", in_ready); end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin miscompares++; $display("[TB] FAIL flush_clear: got valid %b occ %0d expected 0 0", out_valid, occupancy); end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        vectors++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin miscompares++; $display("[TB] FAIL flush_dropped: got valid %b occ %0d expected 0 0", out_valid, occupancy); end
        vectors++;
        if (out_data !== WA) begin miscompares++; $display("[TB] FAIL flush_data_kept: got %h expected %h", out_data, WA); end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, WA, 1'b0, 1'b0);
        tick();
        drive(1'b1, WB, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== '0) begin miscompares++; $display("[TB] FAIL areset_outputs: got valid %b data %h expected 0 0", out_valid, out_data); end
        vectors++;
        if (occupancy !== 2'd0 || in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_occ_ready: got occ %0d ready %b expected 0 0", occupancy, in_ready); end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        tick();
        drive(1'b1, WD, 1'b1, 1'b0);
        tick();
        vectors++;
        if (out_valid !== 1'b0 || occupancy !== 2'd1) begin miscompares++; $display("[TB] FAIL areset_lat_1: got valid %b occ %0d expected 0 1", out_valid, occupancy); end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== WD) begin miscompares++; $display("[TB] FAIL areset_lat_2: got valid %b data %h expected 1 %h", out_valid, out_data, WD); end
    endtask

    task automatic test_stats();
        logic [31:0] exp_bc;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 64'(i + 1), 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        tick();
        exp_bc = STATS ? 32'd5 : 32'd0;
        vectors++;
        if (beat_count !== exp_bc) begin miscompares++; $display("[TB] FAIL stats_five: got %0d expected %0d", beat_count, exp_bc); end
        drive(1'b0, '0, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'(i + 10), 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        tick();
        exp_bc = STATS ? 32'd8 : 32'd0;
        vectors++;
        if (beat_count !== exp_bc) begin miscompares++; $display("[TB] FAIL stats_eight: got %0d expected %0d", beat_count, exp_bc); end
    endtask

    task automatic test_random(input int ncycles);
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [63:0] id;
        bit          exp_rdy;
        bit          exp_ov;
        logic [31:0] exp_bc;
        do_reset();
        mdepth = DEP;
        model_reset();
        for (int c = 0; c < ncycles; c++) begin
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 19) == 0);
            id   = {$urandom, $urandom};
            drive(iv, id, ordy, fl);
            #1;
            exp_rdy = model_in_ready(ordy, fl);
            vectors++;
            if (in_ready !== exp_rdy) begin miscompares++; $display("[TB] FAIL rand_in_ready c=%0d: got %b expected %b", c, in_ready, exp_rdy); end
            tick();
            model_step(iv, id, ordy, fl);
            exp_ov = model_out_valid();
            exp_bc = STATS ? 32'(m_out_count) : 32'd0;
            vectors++;
            if (out_valid !== exp_ov) begin miscompares++; $display("[TB] FAIL rand_out_valid c=%0d: got %b expected %b", c, out_valid, exp_ov); end
            vectors++;
            if (occupancy !== 2'(mq.size())) begin miscompares++; $display("[TB] FAIL rand_occupancy c=%0d: got %0d expected %0d", c, occupancy, mq.size()); end
            if (exp_ov) begin
                vectors++;
                if (out_data !== mq[0].data) begin miscompares++; $display("[TB] FAIL rand_out_data c=%0d: got %h expected %h", c, out_data, mq[0].data); end
            end
            vectors++;
            if (beat_count !== exp_bc) begin miscompares++; $display("[TB] FAIL rand_beat_count c=%0d: got %0d expected %0d", c, beat_count, exp_bc); end
        end
    endtask

    // One stage, downstream ready every other cycle, source always valid:
    // a transfer on every ready cycle after the first, 9 in 20 cycles.
    task automatic test_depth1();
        logic [7:0] seq;
        logic [7:0] next_exp;
        int         got;
        bit         exp_rdy;
        bit         exp_ov;
        bit         ordy;
        do_reset();
        mdepth   = 1;
        model_reset();
        seq      = 8'h40;
        next_exp = 8'h40;
        got      = 0;
        for (int c = 0; c < 20; c++) begin
            ordy       = (c % 2 == 0);
            in_valid1  = 1'b1;
            in_data1   = seq;
            out_ready1 = ordy;
            #1;
            exp_rdy = model_in_ready(ordy, 1'b0);
            vectors++;
            if (in_ready1 !== exp_rdy) begin miscompares++; $display("[TB] FAIL d1_in_ready c=%0d: got %b expected %b", c, in_ready1, exp_rdy); end
            if (out_valid1 === 1'b1 && ordy) begin
                vectors++;
                if (out_data1 !== next_exp) begin miscompares++; $display("[TB] FAIL d1_order c=%0d: got %h expected %h", c, out_data1, next_exp); end
                next_exp++;
                got++;
            end
            tick();
            model_step(1'b1, 64'(seq), ordy, 1'b0);
            if (exp_rdy) seq++;
            exp_ov = model_out_valid();
            vectors++;
            if (out_valid1 !== exp_ov || occupancy1 !== 1'(mq.size())) begin miscompares++; $display("[TB] FAIL d1_state c=%0d: got valid %b occ %0d expected %b %0d", c, out_valid1, occupancy1, exp_ov, mq.size()); end
            if (exp_ov) begin
                vectors++;
                if (out_data1 !== mq[0].data[7:0]) begin miscompares++; $display("[TB] FAIL d1_out_data c=%0d: got %h expected %h", c, out_data1, mq[0].data[7:0]); end
            end
        end
        vectors++;
        if (got != 9) begin miscompares++; $display("[TB] FAIL d1_throughput: got %0d transfers expected 9", got); end
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        flush1      = 1'b0;
        in_valid1   = 1'b0;
        out_ready1  = 1'b0;
        in_data1    = '0;
        drive(1'b0, '0, 1'b0, 1'b0);
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_stats();
        test_random(400);
        test_depth1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
